// File: rtl/aes_pkg.sv
// Shared AES-128 helpers: GF(2^8) arithmetic, S-boxes, key-schedule step, FSM state type.
package aes_pkg;

  localparam int unsigned NR = 10;
  localparam int unsigned BW = 128;
  localparam int unsigned CW = 4;

  typedef enum logic [2:0] {
    S_NOKEY,
    S_KEXP,
    S_IDLE,
    S_ROUND,
    S_DONE
  } state_e;

  function automatic logic [7:0] rcon(input logic [CW-1:0] i);
    case (i)
      4'd0:    rcon = 8'h01;
      4'd1:    rcon = 8'h02;
      4'd2:    rcon = 8'h04;
      4'd3:    rcon = 8'h08;
      4'd4:    rcon = 8'h10;
      4'd5:    rcon = 8'h20;
      4'd6:    rcon = 8'h40;
      4'd7:    rcon = 8'h80;
      4'd8:    rcon = 8'h1b;
      4'd9:    rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  // MSB index of state byte s[r][c]; byte 0 sits in bits [127:120].
  function automatic logic [6:0] bidx(input logic [1:0] r, input logic [1:0] c);
    return 7'(127 - 8 * (4 * int'(c) + int'(r)));
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] p;
    logic [7:0] q;
    r = 8'h00;
    p = a;
    q = b;
    for (int i = 0; i < 8; i++) begin
      if (q[0]) r = r ^ p;
      p = xtime(p);
      q = q >> 1;
    end
    return r;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0).
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] x;
    x = ginv(a);
    return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    logic [7:0] y;
    y = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    return ginv(y);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  // Forward key-schedule step, shared with the encryptor.
  function automatic logic [BW-1:0] gen_key_step(input logic [BW-1:0] k, input logic [7:0] rc);
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] w2;
    logic [31:0] w3;
    w0 = k[127:96] ^ sub_word(rot_word(k[31:0])) ^ {rc, 24'h000000};
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [7:0] imix_coef(input logic [1:0] d);
    case (d)
      2'd0:    imix_coef = 8'h0e;
      2'd1:    imix_coef = 8'h0b;
      2'd2:    imix_coef = 8'h0d;
      default: imix_coef = 8'h09;
    endcase
  endfunction

endpackage

// File: rtl/inv_round.sv
// One combinational inverse round: InvShiftRows, InvSubBytes, AddRoundKey, optional InvMixColumns.
module inv_round
  import aes_pkg::*;
(
  input  logic [BW-1:0] data_in,
  input  logic [BW-1:0] key_in,
  input  logic          no_mix,
  output logic [BW-1:0] data_out
);

  logic [BW-1:0] shifted;
  logic [BW-1:0] keyed;
  logic [BW-1:0] mixed;
  logic [7:0]    acc;

  always_comb begin
    shifted = '0;
    keyed   = '0;
    mixed   = '0;
    acc     = 8'h00;
    // Row r rotates right by r columns.
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        shifted[bidx(2'(r), 2'(c)) -: 8] = data_in[bidx(2'(r), 2'(c - r)) -: 8];
      end
    end
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        keyed[bidx(2'(r), 2'(c)) -: 8] =
          inv_sbox(shifted[bidx(2'(r), 2'(c)) -: 8]) ^ key_in[bidx(2'(r), 2'(c)) -: 8];
      end
    end
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) begin
          acc = acc ^ gmul(imix_coef(2'(j - r)), keyed[bidx(2'(j), 2'(c)) -: 8]);
        end
        mixed[bidx(2'(r), 2'(c)) -: 8] = acc;
      end
    end
    data_out = no_mix ? keyed : mixed;
  end

endmodule

// File: rtl/aes128_decrypt_iter.sv
// Iterative AES-128 inverse cipher: one round per clock, round keys walked backwards from the cached last key.
module aes128_decrypt_iter
  import aes_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic [BW-1:0] key_in,
  input  logic          key_valid,
  output logic          key_ready,
  input  logic [BW-1:0] data_in,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [BW-1:0] data_out,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          key_loaded
);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] kwork_q, kwork_d;
  logic [BW-1:0] klast_q, klast_d;
  logic [BW-1:0] st_q, st_d;
  logic [BW-1:0] data_out_q, data_out_d;
  logic          out_valid_q, out_valid_d;
  logic          key_loaded_q, key_loaded_d;

  logic [CW-1:0] cnt_m1;
  logic [BW-1:0] kfwd;
  logic [BW-1:0] kprev;
  logic [31:0]   pw0, pw1, pw2, pw3;
  logic [BW-1:0] round_out;
  logic          last_round;

  assign key_ready  = (state_q == S_NOKEY) || (state_q == S_IDLE);
  assign in_ready   = (state_q == S_IDLE) && !key_valid;
  assign data_out   = data_out_q;
  assign out_valid  = out_valid_q;
  assign key_loaded = key_loaded_q;

  // Inverse key step recovers round key cnt-1 from round key cnt.
  always_comb begin
    cnt_m1 = cnt_q - 4'd1;
    kfwd   = gen_key_step(kwork_q, rcon(cnt_q));
    pw3    = kwork_q[31:0] ^ kwork_q[63:32];
    pw2    = kwork_q[63:32] ^ kwork_q[95:64];
    pw1    = kwork_q[95:64] ^ kwork_q[127:96];
    pw0    = kwork_q[127:96] ^ sub_word(rot_word(pw3)) ^ {rcon(cnt_m1), 24'h000000};
    kprev  = {pw0, pw1, pw2, pw3};
  end

  assign last_round = (cnt_q == 4'd1);

  inv_round u_inv_round (
    .data_in (st_q),
    .key_in  (kprev),
    .no_mix  (last_round),
    .data_out(round_out)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    kwork_d      = kwork_q;
    klast_d      = klast_q;
    st_d         = st_q;
    data_out_d   = data_out_q;
    out_valid_d  = out_valid_q;
    key_loaded_d = key_loaded_q;
    case (state_q)
      S_NOKEY, S_IDLE: begin
        if (key_valid) begin
          kwork_d      = key_in;
          cnt_d        = '0;
          key_loaded_d = 1'b0;
          state_d      = S_KEXP;
        end else if (in_valid && in_ready) begin
          st_d    = data_in ^ klast_q;
          kwork_d = klast_q;
          cnt_d   = CW'(NR);
          state_d = S_ROUND;
        end
      end
      S_KEXP: begin
        kwork_d = kfwd;
        cnt_d   = cnt_q + 4'd1;
        if (cnt_q == CW'(NR - 1)) begin
          klast_d      = kfwd;
          key_loaded_d = 1'b1;
          state_d      = S_IDLE;
        end
      end
      S_ROUND: begin
        st_d    = round_out;
        kwork_d = kprev;
        cnt_d   = cnt_m1;
        if (last_round) begin
          data_out_d  = round_out;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_NOKEY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_NOKEY;
      cnt_q        <= '0;
      kwork_q      <= '0;
      klast_q      <= '0;
      st_q         <= '0;
      data_out_q   <= '0;
      out_valid_q  <= 1'b0;
      key_loaded_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      kwork_q      <= kwork_d;
      klast_q      <= klast_d;
      st_q         <= st_d;
      data_out_q   <= data_out_d;
      out_valid_q  <= out_valid_d;
      key_loaded_q <= key_loaded_d;
    end
  end

endmodule

// File: tb/tb_aes128_decrypt_iter.sv
// Randomized self-checking bench for aes128_decrypt_iter against a table-driven AES-128 decrypt model.
module tb_aes128_decrypt_iter;
  import aes_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] key_in;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] data_in;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] data_out;
  logic         out_valid;
  logic         out_ready;
  logic         key_loaded;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  sb  [256];
  logic [7:0]  isb [256];
  logic [31:0] kw  [44];

  always #5 clk = ~clk;

  aes128_decrypt_iter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_in    (key_in),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .data_in   (data_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_out  (data_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .key_loaded(key_loaded)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] rl(input logic [7:0] a, input int n);
    return 8'((a << n) | (a >> (8 - n)));
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) r = r ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return r;
  endfunction

  // S-box from the multiply-by-3 / divide-by-3 generator walk.
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rl(q, 1) ^ rl(q, 2) ^ rl(q, 3) ^ rl(q, 4);
      sb[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
    for (int i = 0; i < 256; i++) isb[sb[i]] = 8'(i);
  endtask

  task automatic expand(input logic [127:0] key);
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) kw[i] = 32'(key >> (96 - 32 * i));
    for (int i = 4; i < 44; i++) begin
      t = kw[i-1];
      if (i % 4 == 0) begin
        t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      kw[i] = kw[i-4] ^ t;
    end
  endtask

  function automatic logic [7:0] rk(input int rd, input int i);
    return 8'(kw[4*rd + i/4] >> (24 - 8 * (i % 4)));
  endfunction

  function automatic logic [127:0] model_dec(input logic [127:0] ct);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] res;
    for (int i = 0; i < 16; i++) s[i] = 8'(ct >> (8 * (15 - i))) ^ rk(10, i);
    for (int rd = 9; rd >= 0; rd--) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[4*c + r] = isb[s[4*((c + 4 - r) % 4) + r]] ^ rk(rd, 4*c + r);
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          s[4*c + r] = (rd == 0) ? t[4*c + r] :
            mul(8'h0e, t[4*c + r]) ^ mul(8'h0b, t[4*c + (r+1)%4]) ^
            mul(8'h0d, t[4*c + (r+2)%4]) ^ mul(8'h09, t[4*c + (r+3)%4]);
    end
    res = '0;
    for (int i = 0; i < 16; i++) res = {res[119:0], s[i]};
    return res;
  endfunction

  // Called and returns on a falling edge; key is accepted on the rising edge in between.
  task automatic load_key(input logic [127:0] k);
    int n;
    key_in = k;
    key_valid = 1'b1;
    n = 0;
    while (!key_ready && n < 100) begin @(negedge clk); n++; end
    check("key_accept", 128'(key_ready), 128'(1));
    @(negedge clk);
    key_valid = 1'b0;
    n = 0;
    while (!key_loaded && n < 40) begin @(negedge clk); n++; end
    check("key_latency", 128'(n), 128'(10));
  endtask

  task automatic send_block(input logic [127:0] ct, input logic [127:0] exp, input int hold);
    int n, k, lowcnt;
    data_in = ct;
    in_valid = 1'b1;
    out_ready = (hold == 0);
    n = 0;
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    check("in_accept", 128'(in_ready), 128'(1));
    @(negedge clk);
    in_valid = 1'b0;
    lowcnt = 0;
    k = 0;
    while (!out_valid && k < 40) begin
      if (!in_ready) lowcnt++;
      @(negedge clk);
      k++;
    end
    if (!in_ready) lowcnt++;
    check("out_latency", 128'(k), 128'(10));
    check("plaintext", data_out, exp);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (!in_ready) lowcnt++;
      check("hold_valid", 128'(out_valid), 128'(1));
      check("hold_data", data_out, exp);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("out_drop", 128'(out_valid), 128'(0));
    check("in_ready_gap", 128'(lowcnt), 128'(11 + hold));
    check("in_ready_back", 128'(in_ready), 128'(1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] k, ct, exp;
    rst_n = 1'b0;
    key_in = '0;
    key_valid = 1'b0;
    data_in = '0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    build_sbox();

    #12;
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_key_loaded", 128'(key_loaded), 128'(0));
    check("rst_data_out", data_out, '0);
    check("rst_key_ready", 128'(key_ready), 128'(1));
    @(negedge clk);
    rst_n = 1'b1;

    // Data offered before any key: held off until a key is loaded.
    data_in = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("nokey_in_ready", 128'(in_ready), 128'(0));
    end
    check("nokey_key_ready", 128'(key_ready), 128'(1));
    load_key(128'h000102030405060708090a0b0c0d0e0f);
    check("c1_klast", dut.klast_q, 128'h13111d7fe3944a17f307a78b4d2b30c5);
    send_block(128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h00112233445566778899aabbccddeeff, 0);

    load_key(128'h2b7e151628aed2a6abf7158809cf4f3c);
    check("b_klast", dut.klast_q, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    send_block(128'h3925841d02dc09fbdc118597196a0b32, 128'h3243f6a8885a308d313198a2e0370734, 0);
    send_block(128'h3925841d02dc09fbdc118597196a0b32, 128'h3243f6a8885a308d313198a2e0370734, 0);

    load_key('0);
    send_block(128'h66e94bd4ef8a2c3b884cfa59ca342b2e, '0, 20);

    // Key and data offered together in IDLE: key wins.
    k  = {$urandom, $urandom, $urandom, $urandom};
    ct = {$urandom, $urandom, $urandom, $urandom};
    expand(k);
    exp = model_dec(ct);
    key_in = k;
    key_valid = 1'b1;
    data_in = ct;
    in_valid = 1'b1;
    #1;
    check("prio_in_ready", 128'(in_ready), 128'(0));
    check("prio_key_ready", 128'(key_ready), 128'(1));
    load_key(k);
    check("prio_klast", dut.klast_q, {kw[40], kw[41], kw[42], kw[43]});
    send_block(ct, exp, 0);

    for (int it = 0; it < 8; it++) begin
      if (it == 0 || $urandom_range(0, 1) == 1) begin
        k = {$urandom, $urandom, $urandom, $urandom};
        expand(k);
        load_key(k);
        check("rand_klast", dut.klast_q, {kw[40], kw[41], kw[42], kw[43]});
      end
      ct = {$urandom, $urandom, $urandom, $urandom};
      send_block(ct, model_dec(ct), int'($urandom_range(0, 3)));
    end

    // Reset in the middle of a block.
    data_in = {$urandom, $urandom, $urandom, $urandom};
    in_valid = 1'b1;
    check("mid_in_ready", 128'(in_ready), 128'(1));
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_cnt", 128'(dut.cnt_q), 128'(5));
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 128'(out_valid), 128'(0));
    check("mid_rst_key_loaded", 128'(key_loaded), 128'(0));
    check("mid_rst_data_out", data_out, '0);
    check("mid_rst_state", 128'(dut.state_q), 128'(S_NOKEY));
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1;
    #1;
    check("post_rst_key_ready", 128'(key_ready), 128'(1));
    check("post_rst_in_ready", 128'(in_ready), 128'(0));
    in_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
